wb_elastic_reg: RTL

//  Parametrised MEM->WB pipeline register for the multi-issue core. Replaces a plain stall/flush latch

---
 rtl/wb_pkg.sv | 38 +++
 rtl/wb_elastic_reg_if.sv | 33 +++
 rtl/skid_buf2.sv | 72 +++++++
 rtl/wb_elastic_reg.sv | 74 +++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared sizing defaults and payload layout for the MEM->WB elastic register.
// The payload is packed LSB-first: wena, waddr, wdata, ll_ena, ll_data, cp0_ena, cp0_addr, cp0_data, hilo_ena, hi, lo.
package wb_pkg;

   localparam int LANES_DEF   = 2;
   localparam int DATA_W_DEF  = 32;
   localparam int RADDR_W_DEF = 5;
   localparam int CADDR_W_DEF = 5;

   function automatic int payload_w(input int lanes, input int data_w, input int raddr_w,
                                    input int caddr_w);
      return lanes*(1+raddr_w+data_w) + 2 + (1+caddr_w+data_w) + (1+2*data_w);
   endfunction

   function automatic int ofs_waddr(input int lanes);
      return lanes;
   endfunction

   function automatic int ofs_wdata(input int lanes, input int raddr_w);
      return lanes*(1+raddr_w);
   endfunction

   function automatic int ofs_ll(input int lanes, input int raddr_w, input int data_w);
      return lanes*(1+raddr_w+data_w);
   endfunction

   function automatic int ofs_cp0(input int lanes, input int raddr_w, input int data_w);
      return ofs_ll(lanes, raddr_w, data_w) + 2;
   endfunction

   function automatic int ofs_hilo(input int lanes, input int raddr_w, input int data_w,
                                   input int caddr_w);
      return ofs_cp0(lanes, raddr_w, data_w) + 1 + caddr_w + data_w;
   endfunction

   localparam int WB_PAYLOAD_W = payload_w(LANES_DEF, DATA_W_DEF, RADDR_W_DEF, CADDR_W_DEF);

endpackage

// File: rtl/wb_elastic_reg_if.sv
// Valid/ready bundle carrying the GPR write lanes plus LL, CP0 and HI/LO channels.
interface wb_elastic_reg_if #(
   parameter int LANES   = wb_pkg::LANES_DEF,
   parameter int DATA_W  = wb_pkg::DATA_W_DEF,
   parameter int RADDR_W = wb_pkg::RADDR_W_DEF,
   parameter int CADDR_W = wb_pkg::CADDR_W_DEF
);
   logic                       valid;
   logic                       ready;
   logic [LANES-1:0]           wena;
   logic [LANES*RADDR_W-1:0]   waddr;
   logic [LANES*DATA_W-1:0]    wdata;
   logic                       ll_ena;
   logic                       ll_data;
   logic                       cp0_ena;
   logic [CADDR_W-1:0]         cp0_addr;
   logic [DATA_W-1:0]          cp0_data;
   logic                       hilo_ena;
   logic [DATA_W-1:0]          hi;
   logic [DATA_W-1:0]          lo;

   modport master (
      output valid, wena, waddr, wdata, ll_ena, ll_data,
             cp0_ena, cp0_addr, cp0_data, hilo_ena, hi, lo,
      input  ready
   );

   modport slave (
      input  valid, wena, waddr, wdata, ll_ena, ll_data,
             cp0_ena, cp0_addr, cp0_data, hilo_ena, hi, lo,
      output ready
   );
endinterface

// File: rtl/skid_buf2.sv
// Generic 2-entry valid/ready skid buffer; in_ready comes straight from a flop.
// Main entry drives the output, skid entry absorbs one accept while main is stalled.
module skid_buf2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);
   logic         main_valid, main_valid_nx;
   logic         skid_valid, skid_valid_nx;
   logic [W-1:0] main_data, main_data_nx;
   logic [W-1:0] skid_data, skid_data_nx;
   logic         accept, pop;

   assign accept = in_valid & in_ready;
   assign pop    = main_valid & out_ready;

   always_comb begin
      main_valid_nx = main_valid;
      skid_valid_nx = skid_valid;
      main_data_nx  = main_data;
      skid_data_nx  = skid_data;
      if (flush) begin
         main_valid_nx = 1'b0;
         skid_valid_nx = 1'b0;
         main_data_nx  = '0;
         skid_data_nx  = '0;
      end else if (skid_valid) begin
         // in_ready is low here, so nothing can be accepted this cycle
         if (pop) begin
            main_data_nx  = skid_data;
            skid_valid_nx = 1'b0;
            skid_data_nx  = '0;
         end
      end else if (accept && main_valid && !pop) begin
         skid_valid_nx = 1'b1;
         skid_data_nx  = in_data;
      end else if (accept) begin
         main_valid_nx = 1'b1;
         main_data_nx  = in_data;
      end else if (pop) begin
         main_valid_nx = 1'b0;
         main_data_nx  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_data  <= '0;
         skid_data  <= '0;
      end else begin
         main_valid <= main_valid_nx;
         skid_valid <= skid_valid_nx;
         main_data  <= main_data_nx;
         skid_data  <= skid_data_nx;
      end
   end

   assign in_ready  = !skid_valid;
   assign out_valid = main_valid;
   assign out_data  = main_data;

endmodule

// File: rtl/wb_elastic_reg.sv
// Elastic MEM->WB pipeline register: squashes same-destination GPR writes within a bundle,
// buffers through a 2-entry skid buffer and zeroes every output field while the slot is empty.
module wb_elastic_reg
   import wb_pkg::*;
#(
   parameter int LANES   = LANES_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int RADDR_W = RADDR_W_DEF,
   parameter int CADDR_W = CADDR_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   wb_elastic_reg_if.slave      mem,
   wb_elastic_reg_if.master     wb
);
   localparam int W       = payload_w(LANES, DATA_W, RADDR_W, CADDR_W);
   localparam int O_WADDR = ofs_waddr(LANES);
   localparam int O_WDATA = ofs_wdata(LANES, RADDR_W);
   localparam int O_LL    = ofs_ll(LANES, RADDR_W, DATA_W);
   localparam int O_CP0   = ofs_cp0(LANES, RADDR_W, DATA_W);
   localparam int O_HILO  = ofs_hilo(LANES, RADDR_W, DATA_W, CADDR_W);

   logic [LANES-1:0] wena_sq;
   logic [W-1:0]     payload_in;
   logic [W-1:0]     payload_out;
   logic [W-1:0]     payload_gated;
   logic             out_valid;

   // Older lane loses when a younger lane in the same bundle writes the same GPR
   always_comb begin
      wena_sq = mem.wena;
      for (int i = 0; i < LANES; i++) begin
         for (int j = i + 1; j < LANES; j++) begin
            if (mem.wena[i] && mem.wena[j] &&
                (mem.waddr[i*RADDR_W +: RADDR_W] == mem.waddr[j*RADDR_W +: RADDR_W]))
               wena_sq[i] = 1'b0;
         end
      end
   end

   assign payload_in = {mem.lo, mem.hi, mem.hilo_ena,
                        mem.cp0_data, mem.cp0_addr, mem.cp0_ena,
                        mem.ll_data, mem.ll_ena,
                        mem.wdata, mem.waddr, wena_sq};

   skid_buf2 #(.W(W)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (mem.valid),
      .in_ready  (mem.ready),
      .in_data   (payload_in),
      .out_valid (out_valid),
      .out_ready (wb.ready),
      .out_data  (payload_out)
   );

   assign payload_gated = payload_out & {W{out_valid}};

   assign wb.valid    = out_valid;
   assign wb.wena     = payload_gated[O_WADDR-1:0];
   assign wb.waddr    = payload_gated[O_WDATA-1:O_WADDR];
   assign wb.wdata    = payload_gated[O_LL-1:O_WDATA];
   assign wb.ll_ena   = payload_gated[O_LL];
   assign wb.ll_data  = payload_gated[O_LL+1];
   assign wb.cp0_ena  = payload_gated[O_CP0];
   assign wb.cp0_addr = payload_gated[O_CP0+CADDR_W:O_CP0+1];
   assign wb.cp0_data = payload_gated[O_CP0+CADDR_W+DATA_W:O_CP0+CADDR_W+1];
   assign wb.hilo_ena = payload_gated[O_HILO];
   assign wb.hi       = payload_gated[O_HILO+DATA_W:O_HILO+1];
   assign wb.lo       = payload_gated[O_HILO+2*DATA_W:O_HILO+DATA_W+1];

endmodule
